fm_meas_ctrl: RTL and testbench

Measurement sequencer for the FM demodulator path. Enables the demodulator, waits for its filters to settle, then runs a fixed sample gate on the demodulated audio (offset-binary, mid-scale 512). Over that gate it counts zero crossings (modulation frequency) and tracks peak excursion (frequency deviation). An iterative divider then produces the modulation index, and the block drives the demodulator's `mod_freq`, `delta_f` and `mf` results, which are currently tied to zero.

---
 rtl/fm_meas_ctrl.sv | 122 ++++++++++++
 tb/tb_fm_meas_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fm_meas_ctrl.sv
// fm_meas_ctrl: FM demod measurement sequencer (zero crossings, peak deviation, modulation index).
// Define FM_MEAS_CONT_EN for continuous re-measurement without re-settling.
module fm_meas_ctrl #(
  parameter int SETTLE_CYC   = 4096,
  parameter int GATE_SAMPLES = 1000,
  parameter int HYST         = 8,
  parameter int DF_SHIFT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sample_valid,
  input  logic [9:0] sample,
  output logic       demod_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] mod_freq,
  output logic [7:0] delta_f,
  output logic [7:0] mf
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int GW = $clog2(GATE_SAMPLES + 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_SAMPLES - 1);
  localparam logic [9:0]    LO_TH     = 10'(512 - HYST);
  localparam logic [9:0]    HI_TH     = 10'(512 + HYST);
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DIVIDE, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] set_cnt;
  logic [GW-1:0] smp_cnt;
  logic [9:0]    peak, peak_nx, mag, pk_sh;
  logic [7:0]    xings, xings_nx, df, df_in, mfq, rem, rem_nx, mf_res;
  logic          armed, armed_nx, inc, last, ge;
  logic [11:0]   quo, quo_nx;
  logic [8:0]    rem_sh;
  logic [3:0]    div_cnt;
  always_comb begin
    mag      = sample >= 10'd512 ? sample - 10'd512 : 10'd512 - sample;
    peak_nx  = mag > peak ? mag : peak;
    inc      = armed && sample > HI_TH;
    xings_nx = inc && xings != 8'hff ? xings + 8'd1 : xings;
    armed_nx = inc ? 1'b0 : (sample < LO_TH ? 1'b1 : armed);
    last     = sample_valid && smp_cnt == GATE_LAST;
    pk_sh    = peak_nx >> DF_SHIFT;
    df_in    = |pk_sh[9:8] ? 8'hff : pk_sh[7:0];
    rem_sh   = {rem, quo[11]};
    ge       = rem_sh >= {1'b0, mfq};
    rem_nx   = ge ? 8'(rem_sh - {1'b0, mfq}) : rem_sh[7:0];
    quo_nx   = {quo[10:0], ge};
    mf_res   = mfq == 8'd0 ? 8'd0 : (|quo_nx[11:8] ? 8'hff : quo_nx[7:0]);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SETTLE : IDLE;
      SETTLE:  state_nx = set_cnt == SET_LAST ? MEASURE : SETTLE;
      MEASURE: state_nx = last ? DIVIDE : MEASURE;
      DIVIDE:  state_nx = div_cnt == 4'd11 ? DONE : DIVIDE;
`ifdef FM_MEAS_CONT_EN
      DONE:    state_nx = MEASURE;
`else
      DONE:    state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef FM_MEAS_CONT_EN
  assign demod_en = state == SETTLE || state == MEASURE || state == DONE;
`else
  assign demod_en = state == SETTLE || state == MEASURE;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      set_cnt  <= '0;
      smp_cnt  <= '0;
      peak     <= '0;
      xings    <= '0;
      armed    <= 1'b0;
      df       <= '0;
      mfq      <= '0;
      quo      <= '0;
      rem      <= '0;
      div_cnt  <= '0;
      mod_freq <= '0;
      delta_f  <= '0;
      mf       <= '0;
    end else begin
      state   <= state_nx;
      set_cnt <= state == SETTLE ? set_cnt + 1'b1 : '0;
      if (state_nx == MEASURE && state != MEASURE) begin
        smp_cnt <= '0;
        peak    <= '0;
        xings   <= '0;
        armed   <= 1'b0;
      end else if (state == MEASURE && sample_valid) begin
        smp_cnt <= smp_cnt + 1'b1;
        peak    <= peak_nx;
        xings   <= xings_nx;
        armed   <= armed_nx;
      end
      // operands latched from the final sample's updated peak/crossings
      if (state == MEASURE && last) begin
        df      <= df_in;
        mfq     <= xings_nx;
        quo     <= {df_in, 4'b0};
        rem     <= '0;
        div_cnt <= '0;
      end else if (state == DIVIDE) begin
        quo     <= quo_nx;
        rem     <= rem_nx;
        div_cnt <= div_cnt + 4'd1;
      end
      if (state == DIVIDE && state_nx == DONE) begin
        mod_freq <= mfq;
        delta_f  <= df;
        mf       <= mf_res;
      end
    end
endmodule

// File: tb/tb_fm_meas_ctrl.sv
// tb_fm_meas_ctrl: randomized self-checking bench for fm_meas_ctrl against a behavioural model.
module tb_fm_meas_ctrl;
  localparam int SC = 16, GS = 1000, HY = 8, DS = 2;
  localparam real PI = 3.14159265358979;
  logic clk = 0, rst = 1, start = 0, sample_valid = 0;
  logic [9:0] sample = '0;
  logic demod_en, busy, done;
  logic [7:0] mod_freq, delta_f, mf;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int smp[GS];
  int exp_mod, exp_df, exp_mf;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  fm_meas_ctrl #(.SETTLE_CYC(SC), .GATE_SAMPLES(GS), .HYST(HY), .DF_SHIFT(DS)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample(sample),
    .demod_en(demod_en), .busy(busy), .done(done),
    .mod_freq(mod_freq), .delta_f(delta_f), .mf(mf)
  );
  task automatic check(string tag, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int min255(int v);
    return v > 255 ? 255 : v;
  endfunction
  task automatic model;
    int pk, x, m;
    bit arm;
    pk = 0; x = 0; arm = 0;
    foreach (smp[i]) begin
      m = smp[i] >= 512 ? smp[i] - 512 : 512 - smp[i];
      if (m > pk) pk = m;
      if (smp[i] < 512 - HY) arm = 1;
      else if (arm && smp[i] > 512 + HY) begin
        x++;
        arm = 0;
      end
    end
    exp_df  = min255(pk >> DS);
    exp_mod = min255(x);
    exp_mf  = exp_mod == 0 ? 0 : min255(exp_df * 16 / exp_mod);
  endtask
  task automatic gen_sine(int amp, int per, int jit);
    int v;
    for (int i = 0; i < GS; i++) begin
      v = 512 - int'(amp * $sin(2.0 * PI * per * i / GS));
      if (jit > 0) v = v + int'($urandom_range(2 * jit)) - jit;
      smp[i] = v < 0 ? 0 : (v > 1023 ? 1023 : v);
    end
    model;
  endtask
  task automatic start_settle;
    start = 1;
    tick;
    start = 0;
    check("busy_on", busy, 1);
    check("en_on", demod_en, 1);
    for (int c = 0; c < SC; c++) begin
      sample_valid = 1;
      sample = 10'd1023;
      tick;
    end
  endtask
  task automatic gate(int gap, bit poke);
    int g;
    for (int i = 0; i < GS; i++) begin
      g = gap < 0 ? int'($urandom_range(3)) : gap;
      for (int k = 0; k < g; k++) begin
        sample_valid = 0;
        sample = 10'($urandom);
        tick;
      end
      sample_valid = 1;
      sample = 10'(smp[i]);
      if (poke && i == GS / 2) start = 1;
      tick;
      start = 0;
    end
    sample_valid = 0;
  endtask
  task automatic wait_done(string tag);
    int n;
    n = 0;
    check({tag, "_en_div"}, demod_en, 0);
    while (!done && n < 40) begin
      tick;
      n++;
    end
    check({tag, "_done_lat"}, n + 1, 13);
    check({tag, "_mod"}, mod_freq, exp_mod);
    check({tag, "_df"}, delta_f, exp_df);
    check({tag, "_mf"}, mf, exp_mf);
  endtask
  task automatic run(string tag, int gap, bit poke);
    start_settle;
    gate(gap, poke);
    wait_done(tag);
    tick;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_off"}, busy, 0);
  endtask
  initial begin
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_en", demod_en, 0);
    check("rst_done", done, 0);
    check("rst_mod", mod_freq, 0);
    check("rst_df", delta_f, 0);
    check("rst_mf", mf, 0);
    rst = 0;
    tick;
`ifdef FM_MEAS_CONT_EN
    begin
      int last_done;
      gen_sine(200, 5, 0);
      start_settle;
      for (int r = 0; r < 3; r++) begin
        gate(0, 0);
        wait_done("cont");
        check("cont_en_done", demod_en, 1);
        check("cont_busy", busy, 1);
        if (r > 0) check("cont_period", cyc - last_done, GS + 13);
        last_done = cyc;
        tick;
        check("cont_en_meas", demod_en, 1);
      end
    end
`else
    gen_sine(200, 5, 0);
    run("sine", 0, 0);
    check("sine_mod_k", mod_freq, 5);
    check("sine_df_k", delta_f, 50);
    check("sine_mf_k", mf, 160);
    gen_sine(0, 0, 6);
    run("noise", 0, 0);
    check("noise_mod_k", mod_freq, 0);
    check("noise_df_k", delta_f, 1);
    check("noise_mf_k", mf, 0);
    gen_sine(511, 1, 0);
    run("sat", 0, 0);
    check("sat_df_k", delta_f, 127);
    check("sat_mod_k", mod_freq, 1);
    check("sat_mf_k", mf, 255);
    for (int i = 0; i < GS; i++) smp[i] = (i % 2) ? 1023 : 0;
    model;
    run("xsat", 0, 0);
    check("xsat_mod_k", mod_freq, 255);
    gen_sine(300, 7, 3);
    run("gap3", 2, 1);
    for (int r = 0; r < 3; r++) begin
      gen_sine(int'($urandom_range(20, 511)), int'($urandom_range(0, 60)), int'($urandom_range(0, 20)));
      run("rand", -1, r == 0);
    end
    gen_sine(250, 9, 0);
    start_settle;
    gate(0, 0);
    repeat (4) tick;
    #2 rst = 1;
    #1;
    check("rstdiv_busy", busy, 0);
    check("rstdiv_mod", mod_freq, 0);
    check("rstdiv_df", delta_f, 0);
    check("rstdiv_mf", mf, 0);
    @(negedge clk) rst = 0;
    repeat (20) tick;
    check("rstdiv_idle", busy, 0);
    check("rstdiv_nodone", done, 0);
    start = 1;
    tick;
    start = 0;
    repeat (3) tick;
    #2 rst = 1;
    #1;
    check("rst_async_en", demod_en, 0);
    @(negedge clk) rst = 0;
    tick;
    gen_sine(150, 3, 2);
    run("recover", 0, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
